// File: rtl/mips_mem_responder_pkg.sv
// Shared types and constants for the MangoMIPS SRAM-style memory responder.
package mips_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          BE_W      = 4;
    localparam int          CNT_W     = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as a bit mask over q[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] merge_bytes(input logic [31:0]     old_word,
                                                input logic [31:0]     new_data,
                                                input logic [BE_W-1:0] be);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < BE_W; i++)
            if (be[i]) w[8*i +: 8] = new_data[8*i +: 8];
        return w;
    endfunction

endpackage

// File: rtl/mips_mem_responder_lfsr.sv
// 16-bit Fibonacci LFSR used to randomize wait states; advances once per step.
module mem_resp_lfsr
    import mips_mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= LFSR_SEED;
        else if (step)
            q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/mips_mem_responder.sv
// SRAM-style slave for the MangoMIPS iram/dram ports with programmable wait states.
// Define MEM_RESP_RANDOM_WAIT_EN for LFSR-driven wait counts of 1..WAIT_CYCLES.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [31:0]     addr,
    input  logic [BE_W-1:0] wen,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            sreq,
    input  logic            stall
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t             state;
    logic [IDX_W-1:0]   idx_q;
    logic [BE_W-1:0]    wen_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   wait_w;

    logic [31:0]        mem [DEPTH];

    logic               accept, fire;
    logic [IDX_W-1:0]   acc_idx;
    logic [BE_W-1:0]    acc_wen;
    logic [31:0]        acc_wdata;
    logic [31:0]        merged;

    logic               unused_addr;
    assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

`ifdef MEM_RESP_RANDOM_WAIT_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    mem_resp_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (accept),
        .q    (lfsr_q)
    );

    assign wait_w      = CNT_W'((32'(lfsr_q[3:0]) % WAIT_CYCLES) + 1);
    assign unused_lfsr = ^lfsr_q[15:4];
`else
    assign wait_w = CNT_W'(WAIT_CYCLES);
`endif

    assign accept = rst && (state == ST_IDLE) && en;
    assign sreq   = accept || (rst && (state == ST_BUSY));

    // A one-cycle wait completes straight from IDLE using the live request inputs
    assign fire = (accept && wait_w == CNT_W'(1)) ||
                  (rst && state == ST_BUSY && cnt == CNT_W'(1));

    assign acc_idx   = (state == ST_IDLE) ? addr[IDX_W+1:2] : idx_q;
    assign acc_wen   = (state == ST_IDLE) ? wen             : wen_q;
    assign acc_wdata = (state == ST_IDLE) ? wdata           : wdata_q;
    assign merged    = merge_bytes(mem[acc_idx], acc_wdata, acc_wen);

    always_ff @(posedge clk) begin
        if (fire)
            for (int i = 0; i < BE_W; i++)
                if (acc_wen[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata   <= 32'h0000_0000;
        end else begin
            if (fire)
                rdata <= merged;
            unique case (state)
                ST_IDLE: if (en) begin
                    idx_q   <= addr[IDX_W+1:2];
                    wen_q   <= wen;
                    wdata_q <= wdata;
                    // The request cycle itself counts as the first wait state
                    cnt     <= wait_w - CNT_W'(1);
                    state   <= (wait_w == CNT_W'(1)) ? ST_DONE : ST_BUSY;
                end
                ST_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= ST_DONE;
                end
                ST_DONE: if (!stall) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench for mips_mem_responder against a word-array reference model.
module tb_mips_mem_responder;

`ifdef MEM_RESP_RANDOM_WAIT_EN
    localparam int WC = 4;
`else
    localparam int WC = 2;
`endif
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sreq;
    logic        stall;

    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total    = 0;
    logic [31:0] mem_m [int];
    logic [15:0] lfsr_m;

    mips_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .addr  (addr),
        .wen   (wen),
        .wdata (wdata),
        .rdata (rdata),
        .sreq  (sreq),
        .stall (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait count the next accepted request should see
    function automatic int next_wait();
        int w;
`ifdef MEM_RESP_RANDOM_WAIT_EN
        w      = int'(lfsr_m[3:0]) % WC + 1;
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`else
        w = WC;
`endif
        return w;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    task automatic txn(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input int hold, input bit drop_en);
        int          idx, w, n;
        logic [31:0] old, exp;
        idx = word_of(a);
        old = mem_m.exists(idx) ? mem_m[idx] : 32'hxxxx_xxxx;
        exp = (we != 4'b0) ? apply_write(old, wd, we) : old;
        if (we != 4'b0) mem_m[idx] = exp;
        w = next_wait();
        @(negedge clk);
        en = 1'b1; addr = a; wen = we; wdata = wd;
        #1;
        n = 0;
        while (sreq === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            if (drop_en) en = 1'b0;
            #1;
        end
        check("sreq_cycles", 32'(n), 32'(w));
        check("rdata_done", rdata, exp);
        if (hold > 0) begin
            stall = 1'b1;
            wdata = ~wd;
            repeat (hold) begin
                @(negedge clk); #1;
                check("held_sreq", {31'b0, sreq}, 32'b0);
                check("held_rdata", rdata, exp);
            end
        end
        stall = 1'b0; en = 1'b0;
        @(negedge clk); #1;
        check("idle_sreq", {31'b0, sreq}, 32'b0);
        check("idle_rdata", rdata, exp);
    endtask

    task automatic reset_mid_busy(input logic [31:0] a, input logic [31:0] wd);
        int          idx, w;
        idx = word_of(a);
        w   = next_wait();
        @(negedge clk);
        en = 1'b1; addr = a; wen = 4'hF; wdata = wd;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check("rst_sreq", {31'b0, sreq}, 32'b0);
        check("rst_rdata", rdata, 32'h0);
        // A one-cycle wait already committed on the accepting edge
        if (w == 1) mem_m[idx] = wd;
        @(negedge clk); en = 1'b0; wen = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lfsr_m = 16'hACE1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; addr = 32'h0; wen = 4'h0; wdata = 32'h0; stall = 1'b0;
        lfsr_m = 16'hACE1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_sreq_en_high", {31'b0, sreq}, 32'b0);
        check("reset_rdata", rdata, 32'h0);
        en = 1'b0;
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 16; i++) txn(32'(i) << 2, 4'hF, $urandom, 0, 1'b0);

        txn(32'h0000_000C, 4'hF, 32'hDEAD_BEEF, 0, 1'b0);
        txn(32'h0000_000C, 4'h0, 32'h0, 0, 1'b0);

        txn(32'h0000_0014, 4'hF, 32'h1122_3344, 0, 1'b0);
        txn(32'h0000_0014, 4'b0101, 32'hAABB_CCDD, 0, 1'b0);
        txn(32'h0000_0014, 4'h0, 32'h0, 0, 1'b0);

        txn(32'h0000_0014, 4'hF, 32'h1234_5678, 5, 1'b0);
        txn(32'h0000_0014, 4'h0, 32'h0, 0, 1'b0);

        txn(32'h0000_4000, 4'hF, 32'h5A5A_5A5A, 0, 1'b0);
        txn(32'h0000_0000, 4'h0, 32'h0, 0, 1'b0);

        txn(32'h0000_0008, 4'hF, 32'hCAFE_F00D, 0, 1'b1);
        txn(32'h0000_0008, 4'h0, 32'h0, 0, 1'b0);

        reset_mid_busy(32'h0000_0014, 32'h0BAD_0BAD);
        txn(32'h0000_0014, 4'h0, 32'h0, 0, 1'b0);

        for (int k = 0; k < 48; k++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
            txn(a, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the MangoMIPS SRAM-style port (`en`/`addr`/`wen`/`wdata`/`rdata`/`sreq`/`stall`), i.e. the slave end the core's `iram_*` and `dram_*` ports drive.
- Holds a word-addressed on-chip array and answers each request after a programmable number of wait states, raising `sreq` to freeze the pipeline meanwhile.
- Uses `stall` to tell a completed-but-still-held request from a new one.
- One instance serves instruction fetch (`wen` tied 0), another serves data; both are used in system benches and the FPGA top.

## Interface
- `DEPTH`, 4096: array size in 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: stall cycles per transaction; range 1..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  request valid, held by the core while it is stalled.
- `addr`  in  32  byte address (physical, post-MMU).
- `wen`  in  4  byte write enables; bit i writes `wdata[8i+7:8i]`; 0 means read.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; valid while in DONE.
- `sreq`  out  1  stall request to the core's Ctrl.
- `stall`  in  1  core's stall for this stage; high means the core has not consumed the result.

## Operation
- Word index is `addr[log2(DEPTH)+1:2]`. Upper bits and `addr[1:0]` are ignored, so out-of-range addresses alias (wrap) into the array.
- FSM states:
  - IDLE → BUSY when `en`=1; the request is latched (index, `wen`, `wdata`) and the wait counter is loaded with the wait count.
  - BUSY: counter decrements each cycle. At 1 → DONE; the write (byte-masked) commits on that edge, and `rdata` is loaded with the resulting word (post-write contents for writes).
  - DONE → IDLE when `stall`=0; stay in DONE while `stall`=1. `rdata` is held stable and nothing is re-executed.
  - IDLE with `en`=0: stay in IDLE. `rdata` holds its last value.
- `sreq` = (IDLE && `en`) || BUSY. It is combinational, so the core stalls in the same cycle it issues the request.
- `sreq` is 0 in DONE even if `stall`=1; stall from other stages does not affect the responder.
- Request inputs are ignored outside IDLE; latched values are used.
- Array contents are not reset. `rdata` resets to 32'h0000_0000, `sreq` resets to 0, and the state resets to IDLE.

## Timing
- Request in cycle T (IDLE): `sreq`=1 in cycles T..T+W−1, where W is the wait count.
- Cycle T+W: state DONE, `sreq`=0, `rdata` valid. The core captures at the end of T+W if `stall`=0.
- Back-to-back: the next request is accepted in the cycle after leaving DONE. Throughput is one transaction per W+1 cycles minimum.
- Reset mid-operation (BUSY): returns to IDLE immediately. The pending write is dropped, the array is unchanged, and `sreq` goes 0.
- `en` deasserted while BUSY (e.g. core flush): the transaction still completes, including the write, then waits in DONE for `stall`=0.

## Configuration
- `MEM_RESP_RANDOM_WAIT_EN` defined:
  - W per transaction is `(lfsr[3:0] % WAIT_CYCLES) + 1`.
  - `lfsr` is a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset seed 16'hACE1, advanced once per accepted request.
- Not defined: W = `WAIT_CYCLES` for every transaction; no LFSR logic.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the byte-enable width (4);
  - the LFSR seed and taps constants;
  - the wait-counter width (4).
- Sub-module `mem_resp_lfsr`: 16-bit LFSR with `clk`, `rst`, `step`, `q`; instantiated only under the macro.
- The array is a plain reg array with per-byte write for FPGA BRAM inference; no hard-macro wrapper.

## Test plan
- Read, W=2: preload word 3 = 32'hDEAD_BEEF; `en`=1, `addr`=32'h0000_000C, `wen`=0 → `sreq` high for 2 cycles, then `rdata`=32'hDEAD_BEEF, `sreq`=0.
- Byte write: word 5 = 32'h1122_3344; write `wen`=4'b0101, `wdata`=32'hAABB_CCDD at 32'h14 → read back 32'h11BB_33DD; `rdata` in the write's DONE also shows 32'h11BB_33DD.
- Held result: after DONE, keep `stall`=1 and `en`=1 with the same addr for 5 cycles → `sreq` stays 0, `rdata` stable, exactly one array write.
- Wrap: DEPTH=4096, write 32'h5A5A_5A5A to 32'h0000_4000 → read at 32'h0 returns 32'h5A5A_5A5A.
- Reset mid-BUSY: write issued, `rst` low in the first BUSY cycle → `sreq`=0 and `rdata`=0 at once; the later read returns the old contents.
- Macro on, `WAIT_CYCLES`=4: 64 requests → every `sreq` burst is 1..4 cycles and matches the reference LFSR model from seed 16'hACE1.
